// File: rtl/vx_sfu_csr_responder.sv
// rtl/vx_sfu_csr_responder.sv - per-warp, per-thread extension CSR responder with lookup port
//
// Responder end of the SFU CSR interface for an extension unit. Owns the CSR
// window [CSR_BEGIN, CSR_BEGIN+NUM_CSRS) for every warp and thread.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   read_enable/uuid/wid/tmask/pid/addr -> read_data   combinational CSR read
//   write_enable/uuid/wid/tmask/pid/addr/data          CSR write, commits at clk edge
//   lk_req_valid/ready/wid/pid      datapath lookup request
//   lk_rsp_valid/ready/data         lookup response, lane-major [lane][csr][31:0]
//   addr_err                        sticky flag: an enable was seen outside the window
//
// Optional build macro VX_CSR_RESPONDER_PERF_EN adds perf_reads, perf_writes and
// perf_lookups (44-bit wrapping counters of hits and lookup handshakes).

module vx_sfu_csr_responder #(
  parameter int NUM_LANES  = 1,
  parameter int THREAD_CNT = 4,
  parameter int NUM_WARPS  = 4,
  parameter int CSR_BEGIN  = 'h7C0,
  parameter int NUM_CSRS   = 4,
  parameter int UUID_WIDTH = 44,
  parameter int ADDR_BITS  = 12,
  parameter int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PID_WIDTH  = ((THREAD_CNT / NUM_LANES) > 1) ? $clog2(THREAD_CNT / NUM_LANES) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,

  input  logic                            read_enable,
  input  logic [UUID_WIDTH-1:0]           read_uuid,
  input  logic [NW_WIDTH-1:0]             read_wid,
  input  logic [NUM_LANES-1:0]            read_tmask,
  input  logic [PID_WIDTH-1:0]            read_pid,
  input  logic [ADDR_BITS-1:0]            read_addr,
  output logic [NUM_LANES*32-1:0]         read_data,

  input  logic                            write_enable,
  input  logic [UUID_WIDTH-1:0]           write_uuid,
  input  logic [NW_WIDTH-1:0]             write_wid,
  input  logic [NUM_LANES-1:0]            write_tmask,
  input  logic [PID_WIDTH-1:0]            write_pid,
  input  logic [ADDR_BITS-1:0]            write_addr,
  input  logic [NUM_LANES*32-1:0]         write_data,

  input  logic                            lk_req_valid,
  output logic                            lk_req_ready,
  input  logic [NW_WIDTH-1:0]             lk_req_wid,
  input  logic [PID_WIDTH-1:0]            lk_req_pid,
  output logic                            lk_rsp_valid,
  input  logic                            lk_rsp_ready,
  output logic [NUM_LANES*NUM_CSRS*32-1:0] lk_rsp_data,

  output logic                            addr_err
`ifdef VX_CSR_RESPONDER_PERF_EN
  ,
  output logic [43:0]                     perf_reads,
  output logic [43:0]                     perf_writes,
  output logic [43:0]                     perf_lookups
`endif
);

  localparam int TID_WIDTH = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1;
  localparam int IDX_WIDTH = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;
  localparam int CSR_END   = CSR_BEGIN + NUM_CSRS;
  // One extra bit so the window end can sit at 2^ADDR_BITS without wrapping.
  localparam logic [ADDR_BITS:0] CSR_LO = CSR_BEGIN[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] CSR_HI = CSR_END[ADDR_BITS:0];

  logic [31:0] regs [NUM_WARPS][THREAD_CNT][NUM_CSRS];

  function automatic logic [TID_WIDTH-1:0] tid_of(input logic [PID_WIDTH-1:0] pid, input int lane);
    int t;
    t = int'(pid) * NUM_LANES + lane;
    return t[TID_WIDTH-1:0];
  endfunction

  // Address decode
  logic                 read_hit, write_hit;
  logic [ADDR_BITS-1:0] read_off, write_off;
  logic [IDX_WIDTH-1:0] read_idx, write_idx;

  assign read_hit  = ({1'b0, read_addr}  >= CSR_LO) && ({1'b0, read_addr}  < CSR_HI);
  assign write_hit = ({1'b0, write_addr} >= CSR_LO) && ({1'b0, write_addr} < CSR_HI);
  assign read_off  = read_addr  - CSR_LO[ADDR_BITS-1:0];
  assign write_off = write_addr - CSR_LO[ADDR_BITS-1:0];
  assign read_idx  = read_off[IDX_WIDTH-1:0];
  assign write_idx = write_off[IDX_WIDTH-1:0];

  // Trace-only tags and the upper offset bits (already covered by the hit test).
  logic unused_bits;
  assign unused_bits = ^{read_uuid, write_uuid, read_off, write_off};

  // Combinational read: reflects storage before any write committing this cycle.
  always_comb begin
    read_data = '0;
    if (read_enable && read_hit) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (read_tmask[l]) begin
          read_data[l*32 +: 32] = regs[read_wid][tid_of(read_pid, l)][read_idx];
        end
      end
    end
  end

  logic lk_fire;
  assign lk_req_ready = ~lk_rsp_valid | lk_rsp_ready;
  assign lk_fire      = lk_req_valid & lk_req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int t = 0; t < THREAD_CNT; t++) begin
          for (int c = 0; c < NUM_CSRS; c++) begin
            regs[w][t][c] <= '0;
          end
        end
      end
      lk_rsp_valid <= 1'b0;
      lk_rsp_data  <= '0;
      addr_err     <= 1'b0;
    end else begin
      if (write_enable && write_hit) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (write_tmask[l]) begin
            regs[write_wid][tid_of(write_pid, l)][write_idx] <= write_data[l*32 +: 32];
          end
        end
      end

      if ((read_enable && !read_hit) || (write_enable && !write_hit)) begin
        addr_err <= 1'b1;
      end

      // Capture reads the pre-write storage, so a same-cycle write is not seen.
      if (lk_fire) begin
        lk_rsp_valid <= 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
          for (int c = 0; c < NUM_CSRS; c++) begin
            lk_rsp_data[(l*NUM_CSRS + c)*32 +: 32] <= regs[lk_req_wid][tid_of(lk_req_pid, l)][IDX_WIDTH'(c)];
          end
        end
      end else if (lk_rsp_ready) begin
        lk_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef VX_CSR_RESPONDER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_reads   <= '0;
      perf_writes  <= '0;
      perf_lookups <= '0;
    end else begin
      if (read_enable && read_hit)   perf_reads   <= perf_reads + 44'd1;
      if (write_enable && write_hit) perf_writes  <= perf_writes + 44'd1;
      if (lk_fire)                   perf_lookups <= perf_lookups + 44'd1;
    end
  end
`endif

endmodule
